regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 109 ++++++++++
 tb/tb_regfile_sb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Scoreboarded register file: NRD combinational read ports with writeback bypass,
// per-register busy bits for destination reservation, and a registered busy count.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rvalid,
    input  logic                  rsv_en,
    input  logic [ADDR_W-1:0]     rsv_addr,
    output logic                  rsv_ok,
    input  logic                  flush,
    output logic [ADDR_W:0]       busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;
    logic              wr_hit;
    logic [ADDR_W-1:0] rd_addr;

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign wr_hit = we && (waddr != '0);

    // A same-cycle writeback to the target frees it, so the reservation can proceed.
    always_comb begin
        rsv_ok = rsv_en && !flush &&
                 ((rsv_addr == '0) || !busy_q[rsv_addr] || (we && (waddr == rsv_addr)));
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_hit) begin
            mem_d[waddr] = wdata;
        end
    end

    // Writeback clears first, then reservation sets, so same-address collisions stay busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_hit) begin
            busy_d[waddr] = 1'b0;
        end
        if (rsv_ok && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
        busy_cnt_d = popcount(busy_d);
    end

    always_comb begin
        rdata   = '0;
        rvalid  = '0;
        rd_addr = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_addr = raddr[k*ADDR_W +: ADDR_W];
            if (re[k]) begin
                if (rd_addr == '0) begin
                    rvalid[k] = 1'b1;
                end else if (we && (waddr == rd_addr)) begin
                    rdata[k*DATA_W +: DATA_W] = wdata;
                    rvalid[k]                 = 1'b1;
                end else begin
                    rdata[k*DATA_W +: DATA_W] = mem_q[rd_addr];
                    rvalid[k]                 = !busy_q[rd_addr];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q      <= '{default: '0};
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: bypass, reservation, WAW stall,
// flush priority, register-0 rules and asynchronous reset.
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NRD    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  we;
    logic [ADDR_W-1:0]     waddr;
    logic [DATA_W-1:0]     wdata;
    logic [NRD-1:0]        re;
    logic [NRD*ADDR_W-1:0] raddr;
    logic [NRD*DATA_W-1:0] rdata;
    logic [NRD-1:0]        rvalid;
    logic                  rsv_en;
    logic [ADDR_W-1:0]     rsv_addr;
    logic                  rsv_ok;
    logic                  flush;
    logic [ADDR_W:0]       busy_cnt;

    int errors = 0;
    int checks = 0;

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        re    = 2'b11;
        raddr = {a1, a0};
    endtask

    initial begin
        rst = 1'b0;
        idle();
        re = 2'b01;
        raddr = {5'd0, 5'd5};
        #12;
        chk("reset_busy_cnt", 64'(busy_cnt), 64'd0);
        chk("reset_rdata0", 64'(rdata[31:0]), 64'd0);
        chk("reset_rvalid0", 64'(rvalid[0]), 64'd1);
        chk("reset_re_off_rvalid1", 64'(rvalid[1]), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // write r5 with same-cycle bypass on both ports
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        rd(5'd5, 5'd5);
        #1;
        chk("bypass_rdata0", 64'(rdata[31:0]), 64'hDEADBEEF);
        chk("bypass_rvalid", 64'(rvalid), 64'd3);
        chk("bypass_rdata1", 64'(rdata[63:32]), 64'hDEADBEEF);
        tick();
        idle();
        #1;
        chk("stored_r5", 64'(rdata[31:0]), 64'hDEADBEEF);
        chk("stored_r5_rvalid", 64'(rvalid[0]), 64'd1);

        // reserve r3, then WAW stall
        rsv_en = 1'b1; rsv_addr = 5'd3;
        #1;
        chk("rsv_r3_ok", 64'(rsv_ok), 64'd1);
        tick();
        chk("rsv_r3_cnt", 64'(busy_cnt), 64'd1);
        rd(5'd3, 5'd5);
        #1;
        chk("r3_busy_rvalid", 64'(rvalid[0]), 64'd0);
        chk("waw_stall", 64'(rsv_ok), 64'd0);
        tick();
        chk("waw_cnt_unchanged", 64'(busy_cnt), 64'd1);

        // writeback and reserve r3 in the same cycle
        we = 1'b1; waddr = 5'd3; wdata = 32'h12;
        rsv_en = 1'b1; rsv_addr = 5'd3;
        rd(5'd3, 5'd3);
        #1;
        chk("wb_rsv_ok", 64'(rsv_ok), 64'd1);
        chk("wb_rsv_rdata", 64'(rdata[31:0]), 64'h12);
        chk("wb_rsv_rvalid", 64'(rvalid[0]), 64'd1);
        tick();
        idle();
        #1;
        chk("wb_rsv_cnt", 64'(busy_cnt), 64'd1);
        chk("wb_rsv_still_busy", 64'(rvalid[0]), 64'd0);
        chk("wb_rsv_stored", 64'(rdata[31:0]), 64'h12);

        // register 0 ignores writes and reservations
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        rd(5'd0, 5'd0);
        #1;
        chk("r0_rsv_ok", 64'(rsv_ok), 64'd1);
        chk("r0_bypass_none", 64'(rdata), 64'd0);
        chk("r0_rvalid", 64'(rvalid), 64'd3);
        tick();
        idle();
        #1;
        chk("r0_cnt_unchanged", 64'(busy_cnt), 64'd1);
        chk("r0_after", 64'(rdata[31:0]), 64'd0);

        // free r3, then reserve r1, r2, r4
        we = 1'b1; waddr = 5'd3; wdata = 32'h34;
        tick();
        idle();
        chk("r3_freed_cnt", 64'(busy_cnt), 64'd0);
        rsv_en = 1'b1; rsv_addr = 5'd1; tick();
        rsv_addr = 5'd2; tick();
        rsv_addr = 5'd4; tick();
        chk("three_busy_cnt", 64'(busy_cnt), 64'd3);

        // flush beats a reservation; data write still lands
        rsv_en = 1'b1; rsv_addr = 5'd6; flush = 1'b1;
        we = 1'b1; waddr = 5'd9; wdata = 32'hAB;
        #1;
        chk("flush_rsv_ok", 64'(rsv_ok), 64'd0);
        tick();
        idle();
        chk("flush_cnt", 64'(busy_cnt), 64'd0);
        rd(5'd1, 5'd4);
        #1;
        chk("flush_rvalid_r1_r4", 64'(rvalid), 64'd3);
        rd(5'd6, 5'd9);
        #1;
        chk("flush_rvalid_r6_r9", 64'(rvalid), 64'd3);
        chk("flush_write_r9", 64'(rdata[63:32]), 64'hAB);

        // r7=0x55 busy, then asynchronous reset mid-cycle
        we = 1'b1; waddr = 5'd7; wdata = 32'h55;
        tick();
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd7;
        tick();
        idle();
        rd(5'd7, 5'd7);
        #1;
        chk("r7_busy_rvalid", 64'(rvalid[0]), 64'd0);
        chk("r7_busy_cnt", 64'(busy_cnt), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_cnt", 64'(busy_cnt), 64'd0);
        chk("async_rst_r7", 64'(rdata[31:0]), 64'd0);
        chk("async_rst_rvalid", 64'(rvalid[0]), 64'd1);

        // nothing is captured while held in reset
        we = 1'b1; waddr = 5'd10; wdata = 32'h77;
        rsv_en = 1'b1; rsv_addr = 5'd8;
        #1;
        chk("rst_rsv_ok_comb", 64'(rsv_ok), 64'd1);
        tick();
        chk("rst_no_capture_cnt", 64'(busy_cnt), 64'd0);
        idle();
        @(negedge clk);
        rst = 1'b1;
        tick();
        rd(5'd10, 5'd8);
        #1;
        chk("rst_no_write_r10", 64'(rdata[31:0]), 64'd0);
        chk("rst_no_rsv_r8", 64'(rvalid), 64'd3);
        chk("post_rst_cnt", 64'(busy_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
